// File: rtl/regfile_access_ctrl.sv
// Initiator-side sequencer for the 8x16 three-port register file: reads two operands,
// hands them to execute over valid/ready, then writes the result back in one cycle.
module regfile_access_ctrl #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [AW-1:0] req_rs1_i,
    input  logic [AW-1:0] req_rs2_i,
    input  logic [AW-1:0] req_rd_i,
    input  logic          req_wb_i,
    output logic [AW-1:0] ra1_o,
    output logic [AW-1:0] ra2_o,
    input  logic [DW-1:0] rd1_i,
    input  logic [DW-1:0] rd2_i,
    output logic          we3_o,
    output logic [AW-1:0] wa3_o,
    output logic [DW-1:0] wd3_o,
    output logic          op_valid_o,
    input  logic          op_ready_i,
    output logic [DW-1:0] opa_o,
    output logic [DW-1:0] opb_o,
    input  logic          res_valid_i,
    output logic          res_ready_o,
    input  logic [DW-1:0] res_data_i,
    output logic [15:0]   retired_cnt_o
);

    // state    | meaning
    // IDLE     | ready for a request, read addresses parked on the last request
    // FETCH    | register file read in flight, operands captured at end of cycle
    // ISSUE    | operands offered to execute until op_ready
    // WAIT_RES | waiting for the execute result
    // WB       | single-cycle write port strobe (suppressed for r0)
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_RES = 3'd3,
        S_WB       = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic          wb_q, wb_d;
    logic [AW-1:0] ra1_q, ra1_d, ra2_q, ra2_d, wa3_q, wa3_d;
    logic [DW-1:0] wd3_q, wd3_d, opa_q, opa_d, opb_q, opb_d;
    logic          we3_q, we3_d, op_valid_q, op_valid_d;
    logic [15:0]   retired_q, retired_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            wb_q       <= 1'b0;
            ra1_q      <= '0;
            ra2_q      <= '0;
            wa3_q      <= '0;
            wd3_q      <= '0;
            we3_q      <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            op_valid_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            wb_q       <= wb_d;
            ra1_q      <= ra1_d;
            ra2_q      <= ra2_d;
            wa3_q      <= wa3_d;
            wd3_q      <= wd3_d;
            we3_q      <= we3_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            op_valid_q <= op_valid_d;
            retired_q  <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (req_valid_i) state_d = S_FETCH;
            S_FETCH:    state_d = S_ISSUE;
            S_ISSUE:    if (op_valid_q && op_ready_i) state_d = wb_q ? S_WAIT_RES : S_IDLE;
            S_WAIT_RES: if (res_valid_i) state_d = S_WB;
            S_WB:       state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        wb_d       = wb_q;
        ra1_d      = ra1_q;
        ra2_d      = ra2_q;
        wa3_d      = wa3_q;
        wd3_d      = wd3_q;
        we3_d      = we3_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        op_valid_d = op_valid_q;
        retired_d  = retired_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    rs1_d = req_rs1_i;
                    rs2_d = req_rs2_i;
                    rd_d  = req_rd_i;
                    wb_d  = req_wb_i;
                    ra1_d = req_rs1_i;
                    ra2_d = req_rs2_i;
                end
            end
            S_FETCH: begin
                // r0 reads as zero regardless of what the array returns
                opa_d      = (rs1_q == '0) ? '0 : rd1_i;
                opb_d      = (rs2_q == '0) ? '0 : rd2_i;
                op_valid_d = 1'b1;
            end
            S_ISSUE: begin
                if (op_valid_q && op_ready_i) begin
                    op_valid_d = 1'b0;
                    if (!wb_q) retired_d = retired_q + 16'd1;
                end
            end
            S_WAIT_RES: begin
                if (res_valid_i) begin
                    wd3_d = res_data_i;
                    wa3_d = rd_q;
                    we3_d = (rd_q != '0);
                end
            end
            S_WB: begin
                we3_d     = 1'b0;
                retired_d = retired_q + 16'd1;
            end
            default: ;
        endcase
    end

    assign req_ready_o   = (state_q == S_IDLE);
    assign res_ready_o   = (state_q == S_WAIT_RES);
    assign ra1_o         = ra1_q;
    assign ra2_o         = ra2_q;
    assign we3_o         = we3_q;
    assign wa3_o         = wa3_q;
    assign wd3_o         = wd3_q;
    assign opa_o         = opa_q;
    assign opb_o         = opb_q;
    assign op_valid_o    = op_valid_q;
    assign retired_cnt_o = retired_q;

endmodule
